// File: rtl/anim_pkg.sv
// Shared constants and enums for the sprite animation path.
// Screen geometry matches the 640x480 hvsync_generator timing.
package anim_pkg;
   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;

   typedef enum logic {LOOP = 1'b0, PINGPONG = 1'b1} anim_mode_t;
   typedef enum logic {RIGHT = 1'b0, LEFT = 1'b1} dir_t;
   typedef enum logic {SEQ_UP = 1'b0, SEQ_DOWN = 1'b1} seq_dir_t;
endpackage

// File: rtl/anim_sequencer.sv
// Hold counter and frame-index sequencer (LOOP / PINGPONG), advanced once per
// frame strobe. All inputs are already frozen for the current video frame.
module anim_sequencer
   import anim_pkg::*;
#(
   parameter int NUM_FRAMES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       fs,
   input  logic       pause,
   input  logic [5:0] hold,
   input  logic       mode,
   output logic [3:0] frame_sel
);
   localparam logic [3:0] LAST = 4'(NUM_FRAMES - 1);

   logic [5:0] hold_cnt_q, hold_cnt_d;
   logic [3:0] frame_q, frame_d;
   seq_dir_t   seq_dir_q, seq_dir_d;
   logic [5:0] hold_lim;
   logic       advance;
   anim_mode_t mode_e;

   assign mode_e    = anim_mode_t'(mode);
   assign frame_sel = frame_q;

   always_comb begin
      hold_cnt_d = hold_cnt_q;
      frame_d    = frame_q;
      seq_dir_d  = seq_dir_q;
      advance    = 1'b0;
      // hold of 0 behaves like 1: advance on every strobe
      hold_lim   = (hold == 6'd0) ? 6'd0 : hold - 6'd1;

      if (fs) begin
         if (mode_e == LOOP) seq_dir_d = SEQ_UP;
         if (!pause) begin
            if (hold_cnt_q >= hold_lim) begin
               hold_cnt_d = 6'd0;
               advance    = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q + 6'd1;
            end
         end
      end

      if (advance) begin
         if (mode_e == LOOP) begin
            frame_d = (frame_q >= LAST) ? 4'd0 : frame_q + 4'd1;
         end else if (LAST == 4'd0) begin
            frame_d = 4'd0;
         end else if (seq_dir_q == SEQ_UP) begin
            // endpoints turn around immediately so they show for one hold period
            if (frame_q >= LAST) begin
               frame_d   = frame_q - 4'd1;
               seq_dir_d = SEQ_DOWN;
            end else begin
               frame_d = frame_q + 4'd1;
            end
         end else begin
            if (frame_q == 4'd0) begin
               frame_d   = 4'd1;
               seq_dir_d = SEQ_UP;
            end else begin
               frame_d = frame_q - 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt_q <= 6'd0;
         frame_q    <= 4'd0;
         seq_dir_q  <= SEQ_UP;
      end else begin
         hold_cnt_q <= hold_cnt_d;
         frame_q    <= frame_d;
         seq_dir_q  <= seq_dir_d;
      end
   end
endmodule

// File: rtl/sprite_animator.sv
// Sprite animation controller: frame strobe, control capture, bouncing motion,
// and a one-cycle registered hit test / sprite-ROM coordinate pipeline.
module sprite_animator
   import anim_pkg::*;
#(
   parameter int NUM_FRAMES = 4,
   parameter int SPRITE_W   = 25,
   parameter int SPRITE_H   = 25,
   parameter int SCALE_LOG2 = 3,
   parameter int POS_Y      = 0,
   parameter int X_INIT     = 256
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] pix_x,
   input  logic [9:0] pix_y,
   input  logic       video_active,
   input  logic [5:0] hold,
   input  logic       mode,
   input  logic       pause,
   input  logic       move_en,
   input  logic [2:0] step,
   output logic [3:0] frame_sel,
   output logic [4:0] rom_x,
   output logic [4:0] rom_y,
   output logic       sprite_hit,
   output logic       mirror
);
   localparam int          BOX_W    = SPRITE_W << SCALE_LOG2;
   localparam int          BOX_H    = SPRITE_H << SCALE_LOG2;
   localparam logic [10:0] BOX_W_V  = 11'(BOX_W);
   localparam logic [10:0] BOX_H_V  = 11'(BOX_H);
   localparam logic [10:0] X_MAX_V  = 11'(H_ACTIVE - BOX_W);
   localparam logic [10:0] POS_Y_V  = 11'(POS_Y);
   localparam logic [4:0]  ROM_LAST = 5'(SPRITE_W - 1);

   logic       corner, corner_q, corner_d;
   logic       fs_q, fs_d;
   logic [5:0] hold_q, hold_d;
   logic       mode_q, mode_d, pause_q, pause_d, move_en_q, move_en_d;
   logic [2:0] step_q, step_d;
   logic [9:0] pos_x_q, pos_x_d;
   dir_t       dir_q, dir_d;
   logic       hit_q, hit_d;
   logic [4:0] rom_x_q, rom_x_d, rom_y_q, rom_y_d;
   logic [10:0] nxt, dx, dy;
   logic [4:0]  col, row;

   always_comb begin
      corner   = (pix_x == 10'd0) && (pix_y == 10'd0);
      corner_d = corner;
      fs_d     = corner && !corner_q;

      // controls are frozen on the corner pixel and used by the strobe that follows
      hold_d    = fs_d ? hold    : hold_q;
      mode_d    = fs_d ? mode    : mode_q;
      pause_d   = fs_d ? pause   : pause_q;
      move_en_d = fs_d ? move_en : move_en_q;
      step_d    = fs_d ? step    : step_q;

      pos_x_d = pos_x_q;
      dir_d   = dir_q;
      nxt     = 11'd0;
      if (fs_q && move_en_q && !pause_q) begin
         if (dir_q == RIGHT) begin
            nxt = {1'b0, pos_x_q} + {8'b0, step_q};
            if (nxt > X_MAX_V) begin
               pos_x_d = X_MAX_V[9:0];
               dir_d   = LEFT;
            end else begin
               pos_x_d = nxt[9:0];
            end
         end else begin
            nxt = {1'b0, pos_x_q} - {8'b0, step_q};
            if (nxt[10]) begin
               pos_x_d = 10'd0;
               dir_d   = RIGHT;
            end else begin
               pos_x_d = nxt[9:0];
            end
         end
      end

      dx    = {1'b0, pix_x} - {1'b0, pos_x_q};
      dy    = {1'b0, pix_y} - POS_Y_V;
      col   = 5'(dx >> SCALE_LOG2);
      row   = 5'(dy >> SCALE_LOG2);
      hit_d = video_active && !dx[10] && (dx < BOX_W_V) && !dy[10] && (dy < BOX_H_V);
      rom_x_d = 5'd0;
      rom_y_d = 5'd0;
      if (hit_d) begin
         rom_x_d = (dir_q == LEFT) ? ROM_LAST - col : col;
         rom_y_d = row;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         corner_q  <= 1'b0;
         fs_q      <= 1'b0;
         hold_q    <= 6'd0;
         mode_q    <= 1'b0;
         pause_q   <= 1'b0;
         move_en_q <= 1'b0;
         step_q    <= 3'd0;
         pos_x_q   <= 10'(X_INIT);
         dir_q     <= RIGHT;
         hit_q     <= 1'b0;
         rom_x_q   <= 5'd0;
         rom_y_q   <= 5'd0;
      end else begin
         corner_q  <= corner_d;
         fs_q      <= fs_d;
         hold_q    <= hold_d;
         mode_q    <= mode_d;
         pause_q   <= pause_d;
         move_en_q <= move_en_d;
         step_q    <= step_d;
         pos_x_q   <= pos_x_d;
         dir_q     <= dir_d;
         hit_q     <= hit_d;
         rom_x_q   <= rom_x_d;
         rom_y_q   <= rom_y_d;
      end
   end

   anim_sequencer #(.NUM_FRAMES(NUM_FRAMES)) u_seq (
      .clk       (clk),
      .rst_n     (rst_n),
      .fs        (fs_q),
      .pause     (pause_q),
      .hold      (hold_q),
      .mode      (mode_q),
      .frame_sel (frame_sel)
   );

   assign sprite_hit = hit_q;
   assign rom_x      = rom_x_q;
   assign rom_y      = rom_y_q;
   assign mirror     = (dir_q == LEFT);
endmodule

// File: tb/tb_sprite_animator.sv
// Bench for sprite_animator: behavioural model + per-cycle compare, directed
// literal checks for sequencing, bounce, scaling/mirror, pause and async reset.
module tb_sprite_animator;
   localparam int N    = 4;
   localparam int SW   = 25;
   localparam int SH   = 25;
   localparam int S    = 3;
   localparam int XI   = 256;
   localparam int XMAX = 640 - (SW << S);

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] pix_x = 10'd1;
   logic [9:0] pix_y = 10'd0;
   logic       video_active = 1'b0;
   logic [5:0] hold = 6'd1;
   logic       mode = 1'b0, pause = 1'b0, move_en = 1'b0;
   logic [2:0] step = 3'd0;
   logic [3:0] frame_sel, f1;
   logic [4:0] rom_x, rom_y, rx1, ry1;
   logic       sprite_hit, mirror, hit1, mir1;

   int checks = 0;
   int errors = 0;

   sprite_animator dut (
      .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .video_active(video_active),
      .hold(hold), .mode(mode), .pause(pause), .move_en(move_en), .step(step),
      .frame_sel(frame_sel), .rom_x(rom_x), .rom_y(rom_y), .sprite_hit(sprite_hit), .mirror(mirror)
   );

   sprite_animator #(.NUM_FRAMES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .video_active(video_active),
      .hold(hold), .mode(mode), .pause(pause), .move_en(move_en), .step(step),
      .frame_sel(f1), .rom_x(rx1), .rom_y(ry1), .sprite_hit(hit1), .mirror(mir1)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_frame, m_cnt, m_pos, m_rx, m_ry;
   bit m_up, m_left, m_hit, m_cq, m_fs;
   int l_hold, l_mode, l_pause, l_move, l_step;
   logic [25:0] exp_q[$];

   function automatic logic [25:0] pack_model();
      logic [3:0] f;
      logic [4:0] rx, ry;
      logic [9:0] p;
      f  = 4'(m_frame);
      rx = 5'(m_rx);
      ry = 5'(m_ry);
      p  = 10'(m_pos);
      return {f, m_left, m_hit, rx, ry, p};
   endfunction

   task automatic model_reset();
      m_frame = 0; m_cnt = 0; m_up = 1; m_pos = XI; m_left = 0;
      m_cq = 0; m_fs = 0; m_hit = 0; m_rx = 0; m_ry = 0;
      l_hold = 0; l_mode = 0; l_pause = 0; l_move = 0; l_step = 0;
   endtask

   task automatic model_frame();
      int np;
      if (l_mode == 0) m_up = 1;
      if (l_pause == 0) begin
         if (m_cnt >= ((l_hold == 0) ? 1 : l_hold) - 1) begin
            m_cnt = 0;
            if (l_mode == 0) m_frame = (m_frame + 1) % N;
            else if (m_up && m_frame == N - 1) begin m_up = 0; m_frame--; end
            else if (!m_up && m_frame == 0) begin m_up = 1; m_frame++; end
            else m_frame = m_up ? m_frame + 1 : m_frame - 1;
         end else begin
            m_cnt++;
         end
         if (l_move != 0) begin
            np = m_left ? m_pos - l_step : m_pos + l_step;
            if (np < 0) begin m_pos = 0; m_left = 0; end
            else if (np > XMAX) begin m_pos = XMAX; m_left = 1; end
            else m_pos = np;
         end
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      int dx, dy;
      bit corner;
      if (!rst_n) begin
         model_reset();
         exp_q.delete();
         exp_q.push_back(pack_model());
      end else begin
         dx = int'(pix_x) - m_pos;
         dy = int'(pix_y);
         m_hit = video_active && dx >= 0 && dx < (SW << S) && dy >= 0 && dy < (SH << S);
         m_rx  = m_hit ? (m_left ? SW - 1 - dx / (1 << S) : dx / (1 << S)) : 0;
         m_ry  = m_hit ? dy / (1 << S) : 0;
         if (m_fs) model_frame();
         corner = (pix_x == 0) && (pix_y == 0);
         m_fs = corner && !m_cq;
         if (m_fs) begin
            l_hold = hold; l_mode = mode; l_pause = pause; l_move = move_en; l_step = step;
         end
         m_cq = corner;
         exp_q.push_back(pack_model());
      end
   end

   always @(negedge clk) begin
      logic [25:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("cycle_outputs", int'({frame_sel, mirror, sprite_hit, rom_x, rom_y, dut.pos_x_q}), int'(e));
         check("single_frame_sel", int'(f1), 0);
      end
   end

   // ---------------- drivers ----------------
   task automatic drive_pix(input int x, input int y, input bit va);
      @(negedge clk);
      pix_x = 10'(x);
      pix_y = 10'(y);
      video_active = va;
   endtask

   task automatic run_frame(input int npix);
      int x, y;
      repeat (1 + $urandom_range(0, 1)) drive_pix(0, 0, 1'b1);
      for (int i = 0; i < npix; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            x = $urandom_range(0, 799);
            y = $urandom_range(0, 524);
         end else begin
            x = m_pos - 3 + $urandom_range(0, 206);
            y = $urandom_range(0, 203);
         end
         if (x < 0) x = 0;
         if (x == 0 && y == 0) x = 1;
         drive_pix(x, y, $urandom_range(0, 3) != 0);
      end
   endtask

   task automatic probe(input string name, input int x, input int y, input bit va,
                        input int eh, input int erx, input int ery);
      drive_pix(x, y, va);
      @(posedge clk);
      #1;
      check({name, "_hit"}, int'(sprite_hit), eh);
      check({name, "_rom_x"}, int'(rom_x), erx);
      check({name, "_rom_y"}, int'(rom_y), ery);
   endtask

   task automatic check_reset_values(input string name);
      check({name, "_frame"}, int'(frame_sel), 0);
      check({name, "_mirror"}, int'(mirror), 0);
      check({name, "_hit"}, int'(sprite_hit), 0);
      check({name, "_rom_x"}, int'(rom_x), 0);
      check({name, "_rom_y"}, int'(rom_y), 0);
      check({name, "_pos"}, int'(dut.pos_x_q), XI);
   endtask

   int pp_seq[8] = '{2, 3, 2, 1, 0, 1, 2, 3};

   initial begin
      int pos_exp;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst_n = 1'b1;

      // scaling at pos 256, travelling right
      probe("hit_origin", 256, 0, 1'b1, 1, 0, 0);
      probe("miss_right", 456, 0, 1'b1, 0, 0, 0);
      probe("hit_far_corner", 455, 199, 1'b1, 1, 24, 24);
      probe("miss_left", 255, 10, 1'b1, 0, 0, 0);
      probe("blanked", 300, 10, 1'b0, 0, 0, 0);
      probe("hit_scaled", 263, 8, 1'b1, 1, 0, 1);

      hold = 6'd10; mode = 1'b0;
      for (int f = 1; f <= 50; f++) begin
         run_frame(12);
         check("loop_frame", int'(frame_sel), (f / 10) % 4);
      end

      hold = 6'd1; mode = 1'b1;
      for (int f = 0; f < 8; f++) begin
         run_frame(12);
         check("pingpong_frame", int'(frame_sel), pp_seq[f]);
      end

      hold = 6'd0; mode = 1'b0;
      for (int f = 0; f < 4; f++) begin
         run_frame(12);
         check("hold0_frame", int'(frame_sel), f);
      end

      hold = 6'd4; move_en = 1'b1; step = 3'd7;
      for (int k = 1; k <= 30; k++) begin
         run_frame(12);
         pos_exp = (k <= 26) ? XI + 7 * k : XMAX - 7 * (k - 27);
         check("motion_pos", int'(dut.pos_x_q), pos_exp);
         check("motion_mirror", int'(mirror), (k >= 27) ? 1 : 0);
         if (k == 27) begin
            probe("bounce_edge", 440, 0, 1'b1, 1, 24, 0);
            probe("bounce_left_miss", 439, 0, 1'b1, 0, 0, 0);
            probe("mirror_col1", 448, 8, 1'b1, 1, 23, 1);
         end
         if (k == 28) probe("after_bounce", 433, 0, 1'b1, 1, 24, 0);
      end

      pause = 1'b1;
      for (int f = 0; f < 20; f++) begin
         run_frame(10);
         check("pause_frame", int'(frame_sel), 2);
         check("pause_pos", int'(dut.pos_x_q), 419);
      end
      pause = 1'b0;

      for (int f = 0; f < 120; f++) begin
         hold    = 6'($urandom_range(0, 3));
         mode    = 1'($urandom_range(0, 1));
         pause   = ($urandom_range(0, 7) == 0);
         move_en = 1'($urandom_range(0, 1));
         step    = 3'($urandom_range(0, 7));
         run_frame(16);
         if (f == 60) begin
            drive_pix(m_pos + 5, 5, 1'b1);
            #2 rst_n = 1'b0;
            #1 check_reset_values("async_reset");
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
         end
      end

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sprite_animator.md
# sprite_animator

Parametrised animation controller for the VGA sprite path. Generates the animated frame index, a bouncing horizontal sprite position, optional mirroring and integer scaling. It also produces registered sprite-ROM coordinates plus a hit flag for each pixel. It sits between `hvsync_generator` and the sprite frame ROM and palette. Compared with the previous fixed 4-frame counter, it adds a single-pulse frame strobe, programmable hold, loop/ping-pong sequencing, pause, motion and mirroring.

## Interface
- `NUM_FRAMES`, 4: frames in the ROM, 1..16.
- `SPRITE_W`, 25: sprite width in ROM pixels.
- `SPRITE_H`, 25: sprite height in ROM pixels.
- `SCALE_LOG2`, 3: each ROM pixel is drawn as a 2^SCALE_LOG2 square of screen pixels.
- `POS_Y`, 0: fixed top row of the sprite.
- `X_INIT`, 256: pos_x at reset.
- `clk`  in  1  pixel clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `pix_x`  in  10  current column from `hvsync_generator`.
- `pix_y`  in  10  current row from `hvsync_generator`.
- `video_active`  in  1  display_on.
- `hold`  in  6  video frames per animation step; 0 is treated as 1.
- `mode`  in  1  0 = LOOP, 1 = PINGPONG.
- `pause`  in  1  freeze frame index and position.
- `move_en`  in  1  enable horizontal motion.
- `step`  in  3  pixels moved per video frame.
- `frame_sel`  out  4  current animation frame.
- `rom_x`  out  5  sprite-ROM column, already mirrored.
- `rom_y`  out  5  sprite-ROM row.
- `sprite_hit`  out  1  pixel is inside the sprite box and video is active.
- `mirror`  out  1  1 when travelling left.

## Operation
- **Frame strobe `fs`:** one-cycle pulse on the rising edge of (pix_x==0 && pix_y==0). It is edge-detected against a registered copy, so it fires exactly once per video frame.
- **Control sampling:** all control inputs (`hold`, `mode`, `pause`, `move_en`, `step`) are sampled only on `fs`. No state changes mid-frame.
- **Hold counter (6 bit):**
  - On `fs` with !pause: if hold_cnt >= max(hold,1)-1, clear to 0 and advance the frame. Otherwise increment.
  - Lowering `hold` below the current count causes an advance on the next `fs`.
- **LOOP sequencing:** 0,1,…,N-1,0,…
- **PINGPONG sequencing:**
  - 0,1,…,N-1,N-2,…,1,0,1,…
  - Internal `seq_dir` reverses at each end; an endpoint frame is shown for one hold period only.
  - N=1 holds frame 0. N=2 alternates 0,1.
  - Switching mode keeps frame_sel. Entering LOOP forces seq_dir up.
- **Motion:** on `fs` with move_en && !pause, pos_x moves ±step.
  - X_MAX = H_ACTIVE − SPRITE_W·2^SCALE_LOG2.
  - If the next value would be < 0 or > X_MAX, clamp to the bound and flip `dir`.
  - `mirror` = dir (1 = left).
- **Hit test:**
  - dx = pix_x − pos_x and dy = pix_y − POS_Y, each 11-bit signed.
  - Hit when 0 ≤ dx < SPRITE_W<<SCALE_LOG2, 0 ≤ dy < SPRITE_H<<SCALE_LOG2, and video_active.
- **ROM coordinates:**
  - rom_x = mirror ? SPRITE_W−1−(dx>>S) : dx>>S.
  - rom_y = dy>>S.
  - Outside a hit, rom_x and rom_y are forced to 0.

## Timing
- `fs` is asserted one cycle after pix_x==0 && pix_y==0 is seen.
- frame_sel, pos_x, dir and `mirror` update at the end of the `fs` cycle and remain stable for the whole visible frame.
- `sprite_hit`, `rom_x` and `rom_y` are registered, with latency 1 clk from `pix_x`/`pix_y`. The top level delays hsync, vsync and display_on by 1 clk to match.
- Reset values:
  - frame_sel=0, hold_cnt=0, seq_dir=up.
  - pos_x=X_INIT, dir=right (mirror=0).
  - sprite_hit=0, rom_x=0, rom_y=0, `fs`-edge register=0.
- Reset asserted mid-frame clears all state immediately. After release, the first `fs` occurs at the next (0,0) pixel.
- `pause` and `fs` in the same cycle: the registered pause value applies, so the pause takes effect on that strobe.

## Structure
- Package `anim_pkg` holds:
  - H_ACTIVE=640 and V_ACTIVE=480.
  - Enum anim_mode_t {LOOP, PINGPONG}.
  - Enum dir_t {RIGHT, LEFT}.
- Sub-module `anim_sequencer` contains the hold counter, frame index, seq_dir and mode logic, driven by `fs`.
- Motion, hit test and coordinate pipeline stay in `sprite_animator`.

## Test plan
- **LOOP:** N=4, hold=10, mode=0. Run 50 video frames → frame_sel steps 0→1→2→3→0 every 10 frames; exactly one `fs` per frame.
- **PINGPONG:** N=4, hold=1, mode=1 → sequence 0,1,2,3,2,1,0,1. N=1 → always 0.
- **hold=0:** frame advances every video frame, same as hold=1.
- **Motion and bounce:** step=7, move_en=1, X_INIT=X_MAX−3 → pos_x clamps to 440, then mirror=1 and pos_x decrements 433, 426, …
- **Scaling and mirror:**
  - pos_x=256, S=3 → pixel (256,0) gives hit=1, rom_x=0 (mirror=0) or rom_x=24 (mirror=1), one clk later.
  - Pixel (456,0) gives hit=0.
- **Pause and reset:**
  - pause=1 for 20 frames → frame_sel and pos_x are unchanged.
  - rst_n pulsed mid-line → all outputs return to their reset values asynchronously.
